// File: rtl/stream_burst_source.sv
// Valid/ready burst source: one arithmetic-sequence burst per accepted command,
// with per-burst backpressure (stall) statistics.
module stream_burst_source #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_base,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic [LEN_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] stall_q, stall_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            stall_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        step_d  = step_q;
        rem_d   = rem_q;
        stall_d = stall_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    step_d  = cmd_step;
                    rem_d   = cmd_len;
                    stall_d = '0;
                    if (cmd_len != '0) begin
                        state_d = SEND;
                        valid_d = 1'b1;
                        data_d  = cmd_base;
                        last_d  = (cmd_len == LEN_W'(1));
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = data_q + step_q;
                        rem_d  = rem_q - LEN_W'(1);
                        // rem_q counts the beat being transferred, so 2 means one left after it
                        last_d = (rem_q == LEN_W'(2));
                    end
                end else if (valid_q && (stall_q != '1)) begin
                    stall_d = stall_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/stream_burst_source.md
Name: stream_burst_source

Overview:
- Valid/ready stream transmitter that generates one burst per accepted command.
- Drives the input side of the team's single-stage valid/ready pipeline registers and FIFOs as a traffic source.
- Produces an arithmetic data sequence (base, base+step, ...) of programmable length and marks the final beat with out_last.
- Obeys the producer-side handshake rules exactly and reports per-burst backpressure statistics.

Parameters:
WIDTH, 32, data width of cmd_base, cmd_step and out_data
LEN_W, 16, width of the burst-length and stall-counter fields

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  source idle and able to accept a command
cmd_base  input  WIDTH  first data value of the burst
cmd_step  input  WIDTH  increment added per beat
cmd_len  input  LEN_W  number of beats; 0 means an empty burst
out_valid  output  1  stream beat valid
out_ready  input  1  downstream ready
out_data  output  WIDTH  beat payload
out_last  output  1  final beat of the burst
done  output  1  one-cycle pulse after burst completion
busy  output  1  burst in progress
stall_cnt  output  LEN_W  cycles with out_valid=1 and out_ready=0 in the current/last burst

Behaviour:
- Clock and reset: clk; rstn asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_last=0, done=0, busy=0, stall_cnt=0. cmd_ready=1 once rstn deasserts.
- State machine: IDLE and SEND.
- cmd_ready = (state==IDLE); combinational, no dependency on cmd_valid. busy = (state==SEND).
- Command accept: occurs when cmd_valid && cmd_ready at edge T.
  - Latch base, step and len.
  - Clear stall_cnt.
  - If len != 0: go to SEND. At T+1, out_valid=1, out_data=base, out_last=(len==1).
  - If len == 0: stay IDLE, no beats, done=1 for the cycle T+1.
- SEND handshake: a beat transfers when out_valid && out_ready.
  - Not last: out_data <= out_data + step (mod 2^WIDTH, wrap silent); remaining <= remaining-1; out_last=1 when remaining becomes 1.
  - Last: out_valid<=0, out_last<=0, state<=IDLE, done=1 for exactly the next cycle.
- Producer rules:
  - Once out_valid=1, it stays 1 until the handshake.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never depends combinationally on out_ready.
- Throughput: one beat per cycle when out_ready is held high. A burst of N beats occupies exactly N SEND cycles.
- Back-to-back: cmd_ready is high in the same cycle done is high. A new command accepted then yields its first beat one cycle later, giving a minimum 1 idle cycle between bursts.
- stall_cnt: increments each SEND cycle with out_valid && !out_ready and saturates at 2^LEN_W-1. Held after the burst until the next accept clears it.
- cmd_* inputs are ignored outside IDLE. cmd_valid asserted during SEND has no effect until cmd_ready rises.
- out_ready toggling while out_valid=0 has no effect.
- Reset mid-burst: immediately returns all outputs to reset values. The burst is abandoned and no done pulse is issued.
- done is registered, high for exactly one cycle per accepted command, including len=0.

Test Plan:
1. Reset, cmd base=0x10, step=1, len=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 1 cycle after accept; out_last on 0x13 only; done 1 cycle later; stall_cnt=0.
2. Same cmd, out_ready low for 3 cycles during beat 2 -> out_data=0x11 and out_valid held for all 3 cycles; 4 beats delivered in order; stall_cnt=3.
3. base=0xFFFFFFFE, step=3, len=3 -> beats 0xFFFFFFFE, 0x00000001, 0x00000004 (wrap); out_last on third.
4. len=0 -> no out_valid ever; done pulses at T+1; cmd_ready stays 1.
5. Command held valid continuously, len=2 each -> cmd_ready drops during SEND; second burst starts 1 cycle after first done; no beat lost or duplicated.
6. rstn asserted mid-burst after 2 of 5 beats with out_ready=0 -> out_valid, busy, stall_cnt=0 immediately; no done; a fresh command afterwards restarts from its own base.
